alu_rr_scheduler: RTL and testbench

//  Shares one registered ALU (A, B, mode -> Y) between NREQ requesters.

---
 rtl/alu_sched_pkg.sv | 21 ++
 rtl/alu_rr_scheduler_rr_arbiter.sv | 36 +++
 rtl/alu_rr_scheduler.sv | 148 ++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and helpers for the round-robin ALU scheduler.
// No logic of its own; imported by the scheduler and its arbiter.
// Holds the sequencing FSM state encoding and the wrap-around index helper.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Default ALU mode field width used when the top is not overridden.
    localparam int DEF_MODE_W = 2;

    // Next requester index, wrapping from n-1 back to 0.
    function automatic int next_idx(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none of its own; en gates every grant (low -> grant is all zero).
module rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    // Walk the requesters starting at ptr; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (en && !any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any        = 1'b1;
            end
            idx = IDX_W'(next_idx(int'(idx), NREQ));
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered ALU between NREQ requesters, one operation at a time.
// Latency: accept to rsp_valid is ALU_LAT+2 cycles; request period ALU_LAT+3.
// Backpressure: result is held in RESP until rsp_ready; no new grant meanwhile.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int MODE_W  = DEF_MODE_W,
    parameter int Y_W     = 16,
    parameter int ALU_LAT = 1,
    parameter int IDX_W   = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    input  logic [NREQ*MODE_W-1:0]   req_mode,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    output logic [MODE_W-1:0]        alu_mode,
    input  logic [Y_W-1:0]           alu_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDX_W-1:0]         rsp_id,
    output logic [Y_W-1:0]           rsp_y
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gid_q, gid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       alu_a_q, alu_a_d;
    logic [W-1:0]       alu_b_q, alu_b_d;
    logic [MODE_W-1:0]  alu_mode_q, alu_mode_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]   rsp_id_q, rsp_id_d;
    logic [Y_W-1:0]     rsp_y_q, rsp_y_d;

    logic [NREQ-1:0]    arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               arb_en;

    // Grants are only offered while idle, so at most one accept per operation.
    assign arb_en = (state_q == IDLE);

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .en        (arb_en),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign req_ready = arb_grant;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_mode  = alu_mode_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;

    // Sequencing: accept -> drive ALU -> count down latency -> hold result.
    // Operands go straight into the ALU-facing registers on accept so they
    // are already stable in ISSUE and keep their value between operations.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_mode_d  = alu_mode_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    alu_a_d    = req_a[arb_idx*W +: W];
                    alu_b_d    = req_b[arb_idx*W +: W];
                    alu_mode_d = req_mode[arb_idx*MODE_W +: MODE_W];
                    gid_d      = arb_idx;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(ALU_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_y_d     = alu_y;
                    rsp_id_d    = gid_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = IDX_W'(next_idx(int'(gid_q), NREQ));
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gid_q       <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_mode_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gid_q       <= gid_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_mode_q  <= alu_mode_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler with a one-cycle registered ALU model.
// ALU modes: 0 add, 1 subtract, 2 multiply, 3 xor (zero-extended to 16 bits).
// Expected responses are queued at grant time and popped by a separate monitor.
module tb_alu_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_mode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [1:0]  alu_mode;
    logic [15:0] alu_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_y;

    int checks = 0;
    int errors = 0;
    logic [17:0] sb[$];

    alu_rr_scheduler #(
        .NREQ(4), .W(8), .MODE_W(2), .Y_W(16), .ALU_LAT(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_mode  (req_mode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mode  (alu_mode),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y)
    );

    always #5 clk = ~clk;

    // Registered ALU: Y follows operands one clock later.
    always @(posedge clk) begin
        case (alu_mode)
            2'd0:    alu_y <= {8'h00, alu_a} + {8'h00, alu_b};
            2'd1:    alu_y <= {8'h00, alu_a} - {8'h00, alu_b};
            2'd2:    alu_y <= {8'h00, alu_a} * {8'h00, alu_b};
            default: alu_y <= {8'h00, alu_a ^ alu_b};
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed response must match the oldest expectation.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected actual id=%0d y=%0h required none", rsp_id, rsp_y);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_y} !== e) begin
                        errors++;
                        $display("FAIL rsp_data actual id=%0d y=%0h required id=%0d y=%0h",
                                 rsp_id, rsp_y, e[17:16], e[15:0]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Raise request i, wait for its grant, check it, queue the expected result.
    task automatic do_req(input string name, input int i, input logic [7:0] a,
                          input logic [7:0] b, input logic [1:0] m,
                          input logic [15:0] y, input bit push);
        bit got = 1'b0;
        logic [3:0] exp_g;
        logic [1:0] id;
        exp_g = 4'b0001 << i;
        id    = i[1:0];
        req_valid[i] = 1'b1;
        req_a[i*8 +: 8]    = a;
        req_b[i*8 +: 8]    = b;
        req_mode[i*2 +: 2] = m;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
        else      chk(name, {28'h0, req_ready}, {28'h0, exp_g});
        if (push && got) sb.push_back({id, y});
        step();
        req_valid[i] = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid) break;
        end
        chk(name, sb.size(), 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  fa[4]   = '{8'd3, 8'd200, 8'd9, 8'd16};
        logic [7:0]  fb[4]   = '{8'd5, 8'd100, 8'd4, 8'd15};
        logic [1:0]  fm[4]   = '{2'd0, 2'd0, 2'd1, 2'd2};
        logic [15:0] fy[4]   = '{16'd8, 16'd300, 16'd5, 16'd240};
        int          order[5] = '{0, 1, 2, 3, 0};
        int          n;
        int          lat;
        logic [15:0] hold_y;
        logic [1:0]  hold_id;
        logic [1:0]  oid;

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_mode  = '0;
        rsp_ready = 1'b1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", {28'h0, req_ready}, 0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 0);
        chk("rst_rsp_id",    {30'h0, rsp_id}, 0);
        chk("rst_rsp_y",     {16'h0, rsp_y}, 0);
        chk("rst_alu_a",     {24'h0, alu_a}, 0);
        chk("rst_alu_b",     {24'h0, alu_b}, 0);
        chk("rst_alu_mode",  {30'h0, alu_mode}, 0);
        step();

        // 1. Single request: 3 + 5 = 8, response three cycles after accept
        req_valid[0] = 1'b1;
        req_a[7:0] = 8'd3;
        req_b[7:0] = 8'd5;
        req_mode[1:0] = 2'd0;
        @(negedge clk);
        chk("t1_ready", {28'h0, req_ready}, 32'h1);
        sb.push_back({2'd0, 16'd8});
        step();
        req_valid[0] = 1'b0;
        lat = 0;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk("t1_latency", lat, 3);
        drain("t1_drain");

        // 2. Fairness from ptr=0 with all four requesters held valid
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8]    = fa[i];
            req_b[i*8 +: 8]    = fb[i];
            req_mode[i*2 +: 2] = fm[i];
        end
        req_valid = 4'b1111;
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                chk("t2_grant_order", {28'h0, req_ready}, 32'h1 << order[n]);
                oid = order[n][1:0];
                sb.push_back({oid, fy[order[n]]});
                n++;
            end
            step();
            if (n == 5) req_valid = 4'b0000;
        end
        chk("t2_grant_count", n, 5);
        drain("t2_drain");

        // 3. Wrap/skip: grant 2 moves ptr to 3; only req1 -> grant 1, ptr=2
        do_req("t3_set_ptr3", 2, 8'd1, 8'd1, 2'd0, 16'd2, 1'b1);
        drain("t3_drain_a");
        do_req("t3_wrap_grant1", 1, 8'd4, 8'd4, 2'd0, 16'd8, 1'b1);
        drain("t3_drain_b");
        req_valid[1] = 1'b1;
        req_a[15:8] = 8'd6;
        req_b[15:8] = 8'd1;
        req_mode[3:2] = 2'd1;
        do_req("t3_ptr2_grant2", 2, 8'd2, 8'd3, 2'd2, 16'd6, 1'b1);
        do_req("t3_then_grant1", 1, 8'd6, 8'd1, 2'd1, 16'd5, 1'b1);
        drain("t3_drain_c");

        // 4. Back-pressure: result held while rsp_ready is low
        rsp_ready = 1'b0;
        do_req("t4_grant0", 0, 8'd7, 8'd2, 2'd3, 16'd5, 1'b1);
        req_valid[1] = 1'b1;
        req_a[15:8] = 8'd50;
        req_b[15:8] = 8'd20;
        req_mode[3:2] = 2'd1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("t4_rsp_valid", {31'h0, rsp_valid}, 1);
        hold_y  = rsp_y;
        hold_id = rsp_id;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("t4_hold_valid", {31'h0, rsp_valid}, 1);
            chk("t4_hold_y",     {16'h0, rsp_y}, {16'h0, hold_y});
            chk("t4_hold_id",    {30'h0, rsp_id}, {30'h0, hold_id});
            chk("t4_no_ready",   {28'h0, req_ready}, 0);
        end
        step();
        rsp_ready = 1'b1;
        step();
        @(negedge clk);
        chk("t4_idle_grant1", {28'h0, req_ready}, 32'h2);
        sb.push_back({2'd1, 16'd30});
        step();
        req_valid[1] = 1'b0;
        drain("t4_drain");

        // 5. Reset while in WAIT: nothing returned, ptr back to 0
        do_req("t5_grant2", 2, 8'd9, 8'd9, 2'd0, 16'd18, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rsp_valid", {31'h0, rsp_valid}, 0);
        chk("t5_rsp_id",    {30'h0, rsp_id}, 0);
        chk("t5_rsp_y",     {16'h0, rsp_y}, 0);
        chk("t5_alu_a",     {24'h0, alu_a}, 0);
        chk("t5_alu_b",     {24'h0, alu_b}, 0);
        chk("t5_req_ready", {28'h0, req_ready}, 0);
        repeat (6) @(negedge clk);
        step();
        req_valid[3] = 1'b1;
        req_a[31:24] = 8'd255;
        req_b[31:24] = 8'd255;
        req_mode[7:6] = 2'd2;
        do_req("t5_from_ptr0", 1, 8'd1, 8'd2, 2'd0, 16'd3, 1'b1);
        do_req("t5_next3", 3, 8'd255, 8'd255, 2'd2, 16'hFE01, 1'b1);
        drain("t5_drain");

        // 6. Operand stability while the requester's inputs keep changing
        do_req("t6_grant3", 3, 8'h11, 8'h22, 2'd2, 16'd578, 1'b1);
        for (int k = 0; k < 2; k++) begin
            req_a    = $urandom;
            req_b    = $urandom;
            req_mode = 8'($urandom);
            @(negedge clk);
            chk("t6_alu_a",    {24'h0, alu_a}, 32'h11);
            chk("t6_alu_b",    {24'h0, alu_b}, 32'h22);
            chk("t6_alu_mode", {30'h0, alu_mode}, 2);
            step();
        end
        drain("t6_drain");
        chk("t6_keep_a", {24'h0, alu_a}, 32'h11);

        chk("final_queue_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
